// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit (radix-2 shift-add / restoring divide).
// Define MULDIV_WORD_OPS_EN to add the is_word port for the 32-bit *W ops.
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
`ifdef MULDIV_WORD_OPS_EN
  input  logic            is_word,
`endif
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_rd,
  output logic            wb_en
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_FULL =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, last;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        op_q;
  logic              neg_q, rsgn_q, spec_q;

  logic            is_div, a_sgn, b_sgn;
  logic            sa, sb, ovf, spec;
  logic [XLEN-1:0] a_ext, b_ext, rs1_sx;
  logic [XLEN-1:0] min_val, ma, mb;
  logic [XLEN-1:0] lo_init, spec_val;

  assign is_div = op[2];

`ifdef MULDIV_WORD_OPS_EN
  logic        word_in, word_q;
  logic [31:0] w_res;

  assign word_in = is_word &
    (op[2] | (op[1:0] == 2'b00));
  assign a_ext = word_in ?
    {{(XLEN-32){a_sgn & rs1_data[31]}},
     rs1_data[31:0]} : rs1_data;
  assign b_ext = word_in ?
    {{(XLEN-32){b_sgn & rs2_data[31]}},
     rs2_data[31:0]} : rs2_data;
  assign rs1_sx = word_in ?
    {{(XLEN-32){rs1_data[31]}},
     rs1_data[31:0]} : rs1_data;
  assign min_val = word_in ?
    {{(XLEN-31){1'b1}}, 31'd0} : MIN_FULL;
  // word divides start with the dividend
  // in the top half so 32 steps suffice
  assign lo_init = !is_div ? mb :
    (word_in ? ma << (XLEN-32) : ma);
  assign last = word_q ?
    CNT_W'(31) : CNT_W'(XLEN-1);
`else
  assign a_ext   = rs1_data;
  assign b_ext   = rs2_data;
  assign rs1_sx  = rs1_data;
  assign min_val = MIN_FULL;
  assign lo_init = is_div ? ma : mb;
  assign last    = CNT_W'(XLEN-1);
`endif

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (op)
      3'd1, 3'd4, 3'd6: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'd2: a_sgn = 1'b1;
      default: ;
    endcase
`ifdef MULDIV_WORD_OPS_EN
    if (word_in) begin
      a_sgn = op[2] & ~op[0];
      b_sgn = op[2] & ~op[0];
    end
`endif
  end

  assign sa = a_sgn & a_ext[XLEN-1];
  assign sb = b_sgn & b_ext[XLEN-1];
  assign ma = sa ? -a_ext : a_ext;
  assign mb = sb ? -b_ext : b_ext;

  assign ovf = a_sgn &
    (a_ext == min_val) & (&b_ext);

  always_comb begin
    spec     = 1'b0;
    spec_val = '0;
    if (is_div) begin
      if (b_ext == '0) begin
        spec     = 1'b1;
        spec_val = op[1] ? rs1_sx : '1;
      end else if (ovf) begin
        spec     = 1'b1;
        spec_val = op[1] ? '0 : rs1_sx;
      end
    end
  end

  logic [XLEN:0]   msum, rsh;
  logic [XLEN-1:0] diff, rnx;
  logic            ge;

  assign msum = {1'b0, acc[2*XLEN-1:XLEN]} +
    (acc[0] ? {1'b0, opnd} :
     {(XLEN+1){1'b0}});
  assign rsh  = {acc[2*XLEN-1:XLEN],
                 acc[XLEN-1]};
  assign ge   = rsh >= {1'b0, opnd};
  assign diff = rsh[XLEN-1:0] - opnd;
  assign rnx  = ge ? diff : rsh[XLEN-1:0];

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_val;

  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ?
    -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = rsgn_q ?
    -acc[2*XLEN-1:XLEN] :
    acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = '0;
    if (spec_q) begin
      fix_val = acc[XLEN-1:0];
    end else begin
      unique case (op_q)
        3'd0: fix_val = prod[XLEN-1:0];
        3'd1, 3'd2, 3'd3:
          fix_val = prod[2*XLEN-1:XLEN];
        3'd4, 3'd5: fix_val = quo;
        default: fix_val = rem;
      endcase
    end
`ifdef MULDIV_WORD_OPS_EN
    w_res = '0;
    if (word_q && !spec_q) begin
      w_res = !op_q[2] ?
        acc[XLEN-1:XLEN-32] :
        (op_q[1] ? rem[31:0] : quo[31:0]);
      fix_val = {{(XLEN-32){w_res[31]}},
                 w_res};
    end
`endif
  end

  // special divides pass through FIX so
  // their latency is a fixed two cycles
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (start && !flush)
          state_d = spec ? FIX : CALC;
      CALC:
        if (flush)
          state_d = IDLE;
        else if (cnt == last)
          state_d = FIX;
      FIX:
        state_d = flush ? IDLE : DONE;
      DONE:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      rsgn_q <= 1'b0;
      spec_q <= 1'b0;
      result <= '0;
      wb_rd  <= '0;
`ifdef MULDIV_WORD_OPS_EN
      word_q <= 1'b0;
`endif
    end else begin
      state <= state_d;
      unique case (state)
        IDLE:
          if (start && !flush) begin
            op_q   <= op;
            wb_rd  <= rd;
            cnt    <= '0;
            neg_q  <= sa ^ sb;
            rsgn_q <= sa;
            spec_q <= spec;
            opnd   <= is_div ? mb : ma;
            acc    <= {{XLEN{1'b0}},
              spec ? spec_val : lo_init};
`ifdef MULDIV_WORD_OPS_EN
            word_q <= word_in;
`endif
          end
        CALC:
          if (!flush) begin
            cnt <= cnt + 1'b1;
            acc <= op_q[2] ?
              {rnx, acc[XLEN-2:0], ge} :
              {msum, acc[XLEN-1:1]};
          end
        FIX:
          if (!flush)
            result <= fix_val;
        default: ;
      endcase
    end
  end

  assign busy  = state != IDLE;
  assign done  = state == DONE;
  assign wb_en = done & (|wb_rd);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table
// plus abort, reset and ignored-start sequences.
module tb_muldiv_unit;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      op = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic [4:0]      rd = '0;
  logic            busy, done, wb_en;
  logic [XLEN-1:0] result;
  logic [4:0]      wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .flush    (flush),
    .op       (op),
    .rs1_data (rs1),
    .rs2_data (rs2),
    .rd       (rd),
`ifdef MULDIV_WORD_OPS_EN
    .is_word  (1'b0),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .wb_rd    (wb_rd),
    .wb_en    (wb_en)
  );

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0] rd;
    logic [63:0] exp;
    bit         spec;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input string n, input logic [2:0] o,
    input logic [63:0] a, input logic [63:0] b,
    input logic [4:0] r, input logic [63:0] e,
    input bit s);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b;
    v.rd = r; v.exp = e; v.spec = s;
    return v;
  endfunction

  task automatic chk(input string name,
    input logic [63:0] act,
    input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
        name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v,
    input bit poke);
    int k;
    int nb;
    @(negedge clk);
    op = v.op; rs1 = v.a; rs2 = v.b;
    rd = v.rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs1 = 64'h0123456789abcdef;
    rs2 = 64'd3; op = 3'd5; rd = 5'd9;
    nb = busy ? 1 : 0;
    k = 0;
    while (!done && k < 200) begin
      if (poke) start = (k == 10);
      @(posedge clk); #1;
      k++;
      if (busy) nb++;
    end
    chk({v.name, " done"}, done, 1);
    chk({v.name, " lat"}, k,
      v.spec ? 1 : XLEN + 1);
    chk({v.name, " busy"}, nb,
      v.spec ? 2 : XLEN + 2);
    chk({v.name, " res"}, result, v.exp);
    chk({v.name, " wb_rd"}, wb_rd, v.rd);
    chk({v.name, " wb_en"}, wb_en,
      v.rd != 0);
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({v.name, " pulse"}, done, 0);
    chk({v.name, " idle"}, busy, 0);
  endtask

  task automatic abort_op(input bit use_rst,
    input logic [63:0] prev);
    bit seen;
    @(negedge clk);
    op = 3'd0; rs1 = 64'd11; rs2 = 64'd13;
    rd = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    if (use_rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst async busy", busy, 0);
    end else begin
      flush = 1'b1;
    end
    @(posedge clk); #1;
    flush = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort res", result, prev);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort no done", seen, 0);
  endtask

  initial begin
    vecs[0]  = mk("mul", 3'd0, 64'd7, 64'd6,
      5'd5, 64'd42, 0);
    vecs[1]  = mk("mulh", 3'd1, '1, '1,
      5'd6, 64'd0, 0);
    vecs[2]  = mk("mulhu", 3'd3, '1, '1,
      5'd7, 64'hFFFFFFFFFFFFFFFE, 0);
    vecs[3]  = mk("divu", 3'd5, 64'd100, 64'd7,
      5'd8, 64'd14, 0);
    vecs[4]  = mk("remu", 3'd7, 64'd100, 64'd7,
      5'd9, 64'd2, 0);
    vecs[5]  = mk("div neg", 3'd4,
      64'hFFFFFFFFFFFFFFF9, 64'd2,
      5'd10, 64'hFFFFFFFFFFFFFFFD, 0);
    vecs[6]  = mk("rem neg", 3'd6,
      64'hFFFFFFFFFFFFFFF9, 64'd2,
      5'd11, 64'hFFFFFFFFFFFFFFFF, 0);
    vecs[7]  = mk("div by0", 3'd4, 64'd5, 64'd0,
      5'd12, 64'hFFFFFFFFFFFFFFFF, 1);
    vecs[8]  = mk("rem by0", 3'd6, 64'd5, 64'd0,
      5'd13, 64'd5, 1);
    vecs[9]  = mk("divu by0", 3'd5, 64'd5, 64'd0,
      5'd14, 64'hFFFFFFFFFFFFFFFF, 1);
    vecs[10] = mk("div ovf", 3'd4,
      64'h8000000000000000, '1,
      5'd15, 64'h8000000000000000, 1);
    vecs[11] = mk("rem ovf", 3'd6,
      64'h8000000000000000, '1,
      5'd16, 64'd0, 1);
    vecs[12] = mk("mul rd0", 3'd0, 64'd3, 64'd5,
      5'd0, 64'd15, 0);
    vecs[13] = mk("mulhsu", 3'd2, '1, 64'd2,
      5'd17, 64'hFFFFFFFFFFFFFFFF, 0);
    vecs[14] = mk("mul neg", 3'd0,
      64'hFFFFFFFFFFFFFFFD, 64'd5,
      5'd18, 64'hFFFFFFFFFFFFFFF1, 0);
    vecs[15] = mk("div negb", 3'd4, 64'd7,
      64'hFFFFFFFFFFFFFFFE,
      5'd19, 64'hFFFFFFFFFFFFFFFD, 0);
    vecs[16] = mk("rem negb", 3'd6, 64'd7,
      64'hFFFFFFFFFFFFFFFE,
      5'd20, 64'd1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst wb_en", wb_en, 0);
    chk("rst result", result, 0);
    chk("rst wb_rd", wb_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      do_op(vecs[i], i == 0);

    abort_op(0, vecs[NV-1].exp);
    do_op(mk("mul3x3 a", 3'd0, 64'd3, 64'd3,
      5'd1, 64'd9, 0), 0);
    abort_op(1, 64'd0);
    do_op(mk("mul3x3 b", 3'd0, 64'd3, 64'd3,
      5'd2, 64'd9, 0), 0);

    @(negedge clk);
    op = 3'd0; rs1 = 64'd2; rs2 = 64'd2;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
